// File: rtl/q1_piso.sv
// ----------------------------------------------------------------------------
// q1_piso - parallel-in, serial-out shift register
//
// Loads a WIDTH-bit word from din on a load strobe. It then presents that word
// one bit per shift strobe on a single serial output. The upstream controller
// does all sequencing: this block has no handshake, no busy flag and no bit
// counter.
//
// Parameters
//   WIDTH     : width of din and of the shift register (must be >= 2)
//   MSB_FIRST : 1 = serialise MSB first, 0 = serialise LSB first
//   FILL_BIT  : value shifted into the vacated end on every shift
//
// Ports
//   clk   : system clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset, clears the register to zero
//   din   : parallel data word, sampled only when load = 1
//   load  : synchronous parallel-load strobe (has priority over shift)
//   shift : synchronous shift-enable strobe
//   out   : serial data output, taken combinationally from the output end
// ----------------------------------------------------------------------------
module q1_piso #(
    parameter int   WIDTH     = 4,
    parameter int   MSB_FIRST = 1,
    parameter logic FILL_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    input  logic             shift,
    output logic             out
);

    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] w_sr_shifted;

    // The shift direction and the output tap are fixed at elaboration time.
    // The bit presented on out is always the one that leaves first. The fill
    // bit enters at the opposite end, so over-shifting drains the register to
    // FILL_BIT and never recirculates data.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_sr_shifted = {r_sr[WIDTH-2:0], FILL_BIT};
            assign out          = r_sr[WIDTH-1];
        end else begin : g_lsb_first
            assign w_sr_shifted = {FILL_BIT, r_sr[WIDTH-1:1]};
            assign out          = r_sr[0];
        end
    endgenerate

    // Load wins over shift. With neither strobe asserted the word holds, so
    // the serial stream can pause for any number of cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr <= '0;
        end else if (load) begin
            r_sr <= din;
        end else if (shift) begin
            r_sr <= w_sr_shifted;
        end
    end

endmodule

// File: tb/tb_q1_piso.sv
module tb_q1_piso;

    logic       clk;
    logic       rst_n;
    logic [3:0] din;
    logic       load;
    logic       shift;
    logic       out_m;
    logic       out_l;

    int checks   = 0;
    int failures = 0;

    // sel: 0 = MSB-first out, 1 = MSB-first sr, 2 = LSB-first out, 3 = LSB-first sr
    typedef struct {
        string      tag;
        int         sel;
        logic [3:0] exp;
    } sb_t;

    sb_t sb[$];

    q1_piso #(.WIDTH(4), .MSB_FIRST(1), .FILL_BIT(1'b0)) dut_m (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (din),
        .load  (load),
        .shift (shift),
        .out   (out_m)
    );

    q1_piso #(.WIDTH(4), .MSB_FIRST(0), .FILL_BIT(1'b1)) dut_l (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (din),
        .load  (load),
        .shift (shift),
        .out   (out_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] observe(input int sel);
        case (sel)
            0:       return {3'b000, out_m};
            1:       return dut_m.r_sr;
            2:       return {3'b000, out_l};
            default: return dut_l.r_sr;
        endcase
    endfunction

    task automatic drive(input logic l, input logic s, input logic [3:0] d);
        load  = l;
        shift = s;
        din   = d;
    endtask

    task automatic expect_val(input string tag, input int sel, input logic [3:0] v);
        sb_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic check_now();
        sb_t e;
        logic [3:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            checks++;
            assert (obs === e.exp) else begin
                failures++;
                $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.exp);
            end
        end
    endtask

    // Advance one rising edge, then compare everything queued for it.
    task automatic tick();
        @(posedge clk);
        #1;
        check_now();
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 4'b0000);
        @(posedge clk);
        @(posedge clk);
        #1;
        expect_val("rst_out_m", 0, 4'b0000);
        expect_val("rst_sr_m",  1, 4'b0000);
        expect_val("rst_out_l", 2, 4'b0000);
        expect_val("rst_sr_l",  3, 4'b0000);
        check_now();
        rst_n = 1'b1;

        // Asynchronous reset in the middle of a word
        drive(1'b1, 1'b0, 4'b1010);
        expect_val("pre_rst_sr", 1, 4'b1010);
        expect_val("pre_rst_out", 0, 4'b0001);
        tick();
        drive(1'b1, 1'b1, 4'b1111);
        #2;
        rst_n = 1'b0;
        #1;
        expect_val("async_rst_out", 0, 4'b0000);
        expect_val("async_rst_sr",  1, 4'b0000);
        check_now();
        expect_val("rst_override_out", 0, 4'b0000);
        expect_val("rst_override_sr",  1, 4'b0000);
        tick();
        drive(1'b0, 1'b0, 4'b1111);
        #2;
        rst_n = 1'b1;
        expect_val("post_rst_out", 0, 4'b0000);
        expect_val("post_rst_sr",  1, 4'b0000);
        tick();

        // Load and serialise MSB first, then one shift past the word
        drive(1'b1, 1'b0, 4'b1010);
        expect_val("ser_load_out", 0, 4'b0001);
        expect_val("ser_load_sr",  1, 4'b1010);
        tick();
        drive(1'b0, 1'b1, 4'b0000);
        expect_val("ser_sh1_out", 0, 4'b0000);
        expect_val("ser_sh1_sr",  1, 4'b0100);
        tick();
        expect_val("ser_sh2_out", 0, 4'b0001);
        expect_val("ser_sh2_sr",  1, 4'b1000);
        tick();
        expect_val("ser_sh3_out", 0, 4'b0000);
        expect_val("ser_sh3_sr",  1, 4'b0000);
        tick();
        expect_val("ser_sh4_out", 0, 4'b0000);
        expect_val("ser_sh4_sr",  1, 4'b0000);
        tick();

        // Hold between shifts
        drive(1'b1, 1'b0, 4'b1010);
        expect_val("hold_load_out", 0, 4'b0001);
        tick();
        drive(1'b0, 1'b1, 4'b0000);
        expect_val("hold_sh1_out", 0, 4'b0000);
        expect_val("hold_sh1_sr",  1, 4'b0100);
        tick();
        drive(1'b0, 1'b0, 4'b1111);
        expect_val("hold_idle1_out", 0, 4'b0000);
        expect_val("hold_idle1_sr",  1, 4'b0100);
        tick();
        expect_val("hold_idle2_out", 0, 4'b0000);
        expect_val("hold_idle2_sr",  1, 4'b0100);
        tick();
        drive(1'b0, 1'b1, 4'b0000);
        expect_val("hold_sh2_out", 0, 4'b0001);
        expect_val("hold_sh2_sr",  1, 4'b1000);
        tick();
        expect_val("hold_sh3_out", 0, 4'b0000);
        expect_val("hold_sh3_sr",  1, 4'b0000);
        tick();

        // Load has priority over shift
        drive(1'b1, 1'b0, 4'b1010);
        tick();
        drive(1'b0, 1'b1, 4'b0000);
        expect_val("prio_setup_sr", 1, 4'b0100);
        tick();
        drive(1'b1, 1'b1, 4'b1010);
        expect_val("prio_e1_sr",  1, 4'b1010);
        expect_val("prio_e1_out", 0, 4'b0001);
        tick();
        expect_val("prio_e2_sr",  1, 4'b1010);
        expect_val("prio_e2_out", 0, 4'b0001);
        tick();

        // Over-shift drains to the fill bit with no wrap-around
        drive(1'b1, 1'b0, 4'b1111);
        expect_val("ovr_load_out", 0, 4'b0001);
        tick();
        drive(1'b0, 1'b1, 4'b0000);
        expect_val("ovr_sh1_out", 0, 4'b0001);
        tick();
        expect_val("ovr_sh2_out", 0, 4'b0001);
        tick();
        expect_val("ovr_sh3_out", 0, 4'b0001);
        tick();
        expect_val("ovr_sh4_out", 0, 4'b0000);
        tick();
        expect_val("ovr_sh5_out", 0, 4'b0000);
        tick();
        expect_val("ovr_sh6_out", 0, 4'b0000);
        expect_val("ovr_end_sr",  1, 4'b0000);
        tick();

        // LSB-first instance (fill bit 1)
        drive(1'b1, 1'b0, 4'b1010);
        expect_val("lsb_load_out", 2, 4'b0000);
        expect_val("lsb_load_sr",  3, 4'b1010);
        tick();
        drive(1'b0, 1'b1, 4'b0000);
        expect_val("lsb_sh1_out", 2, 4'b0001);
        expect_val("lsb_sh1_sr",  3, 4'b1101);
        tick();
        expect_val("lsb_sh2_out", 2, 4'b0000);
        expect_val("lsb_sh2_sr",  3, 4'b1110);
        tick();
        expect_val("lsb_sh3_out", 2, 4'b0001);
        expect_val("lsb_sh3_sr",  3, 4'b1111);
        tick();
        expect_val("lsb_sh4_out", 2, 4'b0001);
        expect_val("lsb_sh4_sr",  3, 4'b1111);
        tick();

        // Reload mid-word discards the remaining bits
        drive(1'b1, 1'b0, 4'b0110);
        expect_val("reload1_out", 0, 4'b0000);
        tick();
        drive(1'b0, 1'b1, 4'b0000);
        expect_val("reload_sh_out", 0, 4'b0001);
        tick();
        drive(1'b1, 1'b0, 4'b1001);
        expect_val("reload2_out", 0, 4'b0001);
        expect_val("reload2_sr",  1, 4'b1001);
        tick();
        drive(1'b0, 1'b0, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/q1_piso.md
Name: q1_piso

Overview:
- Parallel-in, serial-out (PISO) shift register: one clock, width parameterised, default 4 bits.
- A word is captured from din on a load strobe and then shifted out one bit per shift cycle on a single serial output.
- Used as a small serialiser between a parallel data source and a 1-bit link or a downstream serial consumer.

Parameters:
- WIDTH, 4: width of din and of the internal shift register; must be >= 2.
- MSB_FIRST, 1: 1 = serialise MSB first (shift toward MSB); 0 = serialise LSB first (shift toward LSB).
- FILL_BIT, 1'b0: value shifted into the vacated end of the register on each shift.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  WIDTH  parallel data word, sampled only when load=1.
- load  input  1  synchronous parallel-load strobe.
- shift  input  1  synchronous shift-enable strobe.
- out  output  1  serial data output.

Behaviour:
- Internal state: WIDTH-bit register sr. No other state.
- Reset: rst_n=0 clears sr to all zeros immediately, independent of clk. out=0 while in reset. Reset overrides any load or shift in progress. The first rising edge after rst_n deasserts operates normally.
- out is driven combinationally from sr. It reflects the current bit at the output end: sr[WIDTH-1] if MSB_FIRST=1, sr[0] if MSB_FIRST=0. out is never driven from din directly.
- Per rising edge, in priority order:
  - load=1: sr <= din. Load has priority over shift; load=1 with shift=1 performs the load only.
  - load=0, shift=1, MSB_FIRST=1: sr <= {sr[WIDTH-2:0], FILL_BIT}.
  - load=0, shift=1, MSB_FIRST=0: sr <= {FILL_BIT, sr[WIDTH-1:1]}.
  - load=0, shift=0: sr holds.
- Latency:
  - The first serial bit appears on out one edge after load (the edge that captures din).
  - Each following bit appears one edge after each shift.
  - A full word takes 1 load + (WIDTH-1) shift cycles to present all WIDTH bits.
- Shift can pause: shift=0 cycles between shifts hold both out and sr unchanged.
- Over-shifting: after WIDTH shifts without a load, sr is entirely FILL_BIT and out=FILL_BIT. Further shifts keep it there; there is no wrap-around or recirculation.
- Reload mid-word: a load at any point discards the remaining bits and starts the new word on the next edge.
- There is no handshake, busy flag or bit counter. The upstream controller sequences load and shift.
- X or Z on load/shift is not a supported input. Behaviour is only defined for 0 and 1.

Test Plan:
- Reset: drive rst_n=0 mid-operation with sr=4'b1010, asynchronously between edges -> out=0 immediately. After release with load=shift=0, out stays 0.
- Load and serialise (MSB_FIRST=1): load din=4'b1010 for one edge, then shift=1 for 3 edges -> out sequence 1,0,1,0 across the load edge and the 3 shift edges. A 4th shift gives out=0.
- Hold: load 4'b1010, shift once (out=0), then load=shift=0 for 2 edges -> out stays 0, sr stays 4'b0100. Two more shifts -> out=1 then 0.
- Priority: sr=4'b0100, then load=1, shift=1, din=4'b1010 for 2 edges -> sr=4'b1010 after each edge, out=1. No shifting occurs.
- Over-shift: load 4'b1111, then 6 consecutive shifts -> out=1,1,1,0,0,0 after the respective edges; sr=4'b0000 at the end.
- LSB-first variant (MSB_FIRST=0): load 4'b1010, then 3 shifts -> out sequence 0,1,0,1.
